fetch_stage_bp: RTL and testbench
=================================

Name: fetch_stage_bp

Overview:
Instruction-fetch stage plus IF/ID pipeline register that feeds the decode-stage Controller. It holds PCF and presents it to the external instruction memory. It predicts the next PC with a direct-mapped BTB and 2-bit saturating-counter BHT, then registers InstrD/PCD/PCPlus4D and the prediction for downstream use. The EX stage trains the predictor and redirects fetch on a mispredict.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset
IDX_BITS, 4, log2 of BHT/BTB entries (16); index = PC[IDX_BITS+1:2], tag = PC[31:IDX_BITS+2]
NOP_INSTR, 32'h0000_0013, addi x0,x0,0 bubble inserted on flush

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
PCF  out  32  current fetch address to instruction memory
InstrF  in  32  instruction read combinationally at PCF
StallF  in  1  hold PCF (hazard unit)
StallD  in  1  hold IF/ID register
FlushD  in  1  load bubble into IF/ID
RedirectE  in  1  EX detected mispredict; fetch from RedirectPCE
RedirectPCE  in  32  corrected PC
UpdateE  in  1  EX resolves a branch/jump this cycle
UpdatePCE  in  32  PC of resolved instruction
ActualTakenE  in  1  resolved direction (1 for jumps)
ActualTargetE  in  32  resolved target
IsJumpE  in  1  resolved instruction is unconditional jump
InstrD  out  32  registered instruction to Controller/decoder
PCD  out  32  registered PC
PCPlus4D  out  32  registered PC+4
PredTakenD  out  1  prediction made for InstrD
PredTargetD  out  32  predicted target for InstrD

Behaviour:
- Reset (async, rst_n=0): PCF=RESET_PC; InstrD=NOP_INSTR; PCD=PCPlus4D=PredTargetD=0; PredTakenD=0; all BTB valid=0; all BHT counters=2'b01 (weakly not-taken); BTB jump bits=0.
- Lookup (combinational on PCF): hit = valid[idx] && tag[idx]==PCF tag. PredTakenF = hit && (jump[idx] || bht[idx][1]). PredTargetF = btb_target[idx].
- Next PC priority (one cycle latency, updates on clk edge): 1) RedirectE -> RedirectPCE (overrides StallF); 2) StallF -> hold; 3) PredTakenF -> PredTargetF; 4) PCF+4. 32-bit wrap-around on +4; no exception.
- IF/ID priority: 1) FlushD || RedirectE -> InstrD=NOP_INSTR, PredTakenD=0, PCD/PCPlus4D/PredTargetD=0; 2) StallD -> hold all; 3) load InstrF, PCF, PCF+4, PredTakenF, PredTargetF.
- Training on UpdateE at clk edge (index/tag from UpdatePCE):
  - BHT: ActualTakenE -> saturating increment (max 2'b11); else saturating decrement (min 2'b00). Jumps also increment.
  - BTB: if ActualTakenE, write valid=1, tag, target=ActualTargetE, jump=IsJumpE. Not-taken never invalidates an entry.
- Same-cycle lookup and update of one index: lookup sees the pre-update value; new value is visible next cycle.
- Tag mismatch (alias): no hit, predict PC+4; a taken update overwrites the entry and resets nothing else.
- Update proceeds regardless of StallF/StallD/FlushD.
- Reset asserted mid-operation clears all state immediately; first fetch after release is RESET_PC.
- Fully synchronous except reset; no combinational path from RedirectE to InstrD.

Test Plan:
- Reset release, no stalls, predictor cold -> PCF 0,4,8,C on successive cycles; InstrD lags InstrF by one cycle; PredTakenD=0.
- StallF=StallD=1 for 3 cycles at PCF=8 -> PCF stays 8 and InstrD/PCD hold; released -> PCF=C next edge.
- RedirectE=1, RedirectPCE=0x100, with StallF=1 the same cycle -> PCF=0x100 next cycle; InstrD=0x00000013, PredTakenD=0.
- Two UpdateE with UpdatePCE=0x10, taken, target 0x40 (counter 01->10->11) -> next fetch of 0x10 gives next PCF=0x40; PredTakenD=1, PredTargetD=0x40 with PCD=0x10.
- Then one not-taken update at 0x10 (11->10) -> still predicts taken. Second not-taken (10->01) -> PCF 0x10 is followed by 0x14.
- Jump at 0x20 trained once (IsJumpE=1, target 0x80) -> predicted taken immediately. Fetch of 0x420 (same index, different tag) -> no hit, next PCF=0x424.

Source files
------------

// File: rtl/fetch_stage_bp.sv
// ============================================================================
// fetch_stage_bp : instruction fetch with BTB/BHT branch prediction and the
//                  IF/ID pipeline register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage_bp #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IDX_BITS  = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        UpdateE,
  input  logic [31:0] UpdatePCE,
  input  logic        ActualTakenE,
  input  logic [31:0] ActualTargetE,
  input  logic        IsJumpE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        PredTakenD,
  output logic [31:0] PredTargetD
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // Predictor state
  logic             r_valid  [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [1:0]       r_bht    [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];

  logic [31:0] r_pcf;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_pred_taken_d;
  logic [31:0] r_pred_target_d;

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_W-1:0]    w_f_tag;
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_W-1:0]    w_u_tag;
  logic                w_hit;
  logic                w_pred_taken;
  logic [31:0]         w_pred_target;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_next_pc;
  logic                w_bht_inc;
  logic                w_unused_ok;

  assign w_f_idx = r_pcf[IDX_BITS+1:2];
  assign w_f_tag = r_pcf[31:IDX_BITS+2];
  assign w_u_idx = UpdatePCE[IDX_BITS+1:2];
  assign w_u_tag = UpdatePCE[31:IDX_BITS+2];

  assign w_unused_ok = &{1'b0, UpdatePCE[1:0]};

  // Lookup reads registered state, so a same-cycle update is seen next cycle
  assign w_hit         = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_pred_taken  = w_hit && (r_jump[w_f_idx] || r_bht[w_f_idx][1]);
  assign w_pred_target = r_target[w_f_idx];
  assign w_pc_plus4    = r_pcf + 32'd4;

  // Jumps always count as taken for direction training
  assign w_bht_inc = ActualTakenE || IsJumpE;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (RedirectE) begin
      w_next_pc = RedirectPCE;
    end else if (StallF) begin
      w_next_pc = r_pcf;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf <= RESET_PC;
    end else begin
      r_pcf <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_jump[i]   <= 1'b0;
        r_bht[i]    <= 2'b01;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (UpdateE) begin
      if (w_bht_inc) begin
        if (r_bht[w_u_idx] != 2'b11) begin
          r_bht[w_u_idx] <= r_bht[w_u_idx] + 2'b01;
        end
      end else if (r_bht[w_u_idx] != 2'b00) begin
        r_bht[w_u_idx] <= r_bht[w_u_idx] - 2'b01;
      end
      // Not-taken outcomes leave the BTB entry untouched
      if (ActualTakenE) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= ActualTargetE;
        r_jump[w_u_idx]   <= IsJumpE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d       <= NOP_INSTR;
      r_pc_d          <= '0;
      r_pc_plus4_d    <= '0;
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (FlushD || RedirectE) begin
      r_instr_d       <= NOP_INSTR;
      r_pc_d          <= '0;
      r_pc_plus4_d    <= '0;
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
    end else if (!StallD) begin
      r_instr_d       <= InstrF;
      r_pc_d          <= r_pcf;
      r_pc_plus4_d    <= w_pc_plus4;
      r_pred_taken_d  <= w_pred_taken;
      r_pred_target_d <= w_pred_target;
    end
  end

  assign PCF         = r_pcf;
  assign InstrD      = r_instr_d;
  assign PCD         = r_pc_d;
  assign PCPlus4D    = r_pc_plus4_d;
  assign PredTakenD  = r_pred_taken_d;
  assign PredTargetD = r_pred_target_d;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_bp.sv
// ============================================================================
// tb_fetch_stage_bp : directed plus randomized bench for fetch_stage_bp
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage_bp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallF, StallD, FlushD, RedirectE, UpdateE, ActualTakenE, IsJumpE;
  logic [31:0] RedirectPCE, UpdatePCE, ActualTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D, PredTargetD;
  logic        PredTakenD;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, pc[31:16] ^ 16'h1234};
  endfunction

  assign InstrF = imem(PCF);

  fetch_stage_bp dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .InstrF(InstrF),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .UpdateE(UpdateE), .UpdatePCE(UpdatePCE), .ActualTakenE(ActualTakenE),
    .ActualTargetE(ActualTargetE), .IsJumpE(IsJumpE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PredTakenD(PredTakenD), .PredTargetD(PredTargetD)
  );

  // Reference model: 16-entry table indexed by (pc/4) mod 16, tag = pc/64
  bit          m_valid [16];
  bit          m_jump  [16];
  int          m_ctr   [16];
  bit [31:0]   m_tag   [16];
  bit [31:0]   m_tgt   [16];
  bit [31:0]   m_pcf, m_instr, m_pcd, m_pc4d, m_ptgtd;
  bit          m_ptd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_jump[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_pcf = 0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptd = 0; m_ptgtd = 0;
  endtask

  task automatic compare_all();
    check("PCF", PCF, m_pcf);
    check("InstrD", InstrD, m_instr);
    check("PCD", PCD, m_pcd);
    check("PCPlus4D", PCPlus4D, m_pc4d);
    check("PredTakenD", {31'd0, PredTakenD}, {31'd0, m_ptd});
    check("PredTargetD", PredTargetD, m_ptgtd);
  endtask

  task automatic idle();
    StallF = 0; StallD = 0; FlushD = 0; RedirectE = 0; RedirectPCE = 0;
    UpdateE = 0; UpdatePCE = 0; ActualTakenE = 0; ActualTargetE = 0; IsJumpE = 0;
  endtask

  // Advance one clock: model evaluates from current state, then both commit
  task automatic step();
    int        fi, ui;
    bit        hit, pt;
    bit [31:0] ptgt, npc;
    fi   = int'(m_pcf / 4) % 16;
    hit  = m_valid[fi] && (m_tag[fi] == m_pcf / 64);
    pt   = hit && (m_jump[fi] || m_ctr[fi] >= 2);
    ptgt = m_tgt[fi];
    if (RedirectE)   npc = RedirectPCE;
    else if (StallF) npc = m_pcf;
    else if (pt)     npc = ptgt;
    else             npc = m_pcf + 4;
    @(posedge clk);
    #1;
    if (FlushD || RedirectE) begin
      m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_ptd = 0; m_ptgtd = 0;
    end else if (!StallD) begin
      m_instr = imem(m_pcf); m_pcd = m_pcf; m_pc4d = m_pcf + 4; m_ptd = pt; m_ptgtd = ptgt;
    end
    if (UpdateE) begin
      ui = int'(UpdatePCE / 4) % 16;
      if (ActualTakenE || IsJumpE) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
      else                         m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      if (ActualTakenE) begin
        m_valid[ui] = 1; m_tag[ui] = UpdatePCE / 64; m_tgt[ui] = ActualTargetE; m_jump[ui] = IsJumpE;
      end
    end
    m_pcf = npc;
    compare_all();
  endtask

  task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt, input bit jmp);
    idle();
    UpdateE = 1; UpdatePCE = pc; ActualTakenE = taken; ActualTargetE = tgt; IsJumpE = jmp;
    step();
    idle();
  endtask

  task automatic redirect(input logic [31:0] pc);
    idle();
    RedirectE = 1; RedirectPCE = pc;
    step();
    idle();
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
    return (32'($urandom_range(0, 31)) << 2) | ($urandom_range(0, 1) ? 32'h400 : 32'h0);
  endfunction

  task automatic async_reset();
    rst_n = 0;
    #2;
    model_reset();
    compare_all();
    rst_n = 1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1;

    // Cold sequential fetch and stall hold
    step(); check("seq_pc4", PCF, 32'h4);
    step(); check("seq_pc8", PCF, 32'h8);
    StallF = 1; StallD = 1;
    repeat (3) step();
    check("stall_hold", PCF, 32'h8);
    idle();
    step(); check("stall_release", PCF, 32'hC);

    // Redirect overrides StallF and flushes IF/ID
    idle(); StallF = 1; RedirectE = 1; RedirectPCE = 32'h100;
    step(); idle();
    check("redir_pc", PCF, 32'h100);
    check("redir_nop", InstrD, NOP);

    // Train 0x10 taken twice, then fetch it
    train(32'h10, 1, 32'h40, 0);
    train(32'h10, 1, 32'h40, 0);
    redirect(32'h10);
    step();
    check("bp_taken_pc", PCF, 32'h40);
    check("bp_taken_d", {31'd0, PredTakenD}, 32'd1);
    check("bp_pcd", PCD, 32'h10);
    check("bp_tgtd", PredTargetD, 32'h40);

    // 11 -> 10 still taken; 10 -> 01 falls through
    train(32'h10, 0, 32'h0, 0);
    redirect(32'h10);
    step(); check("weak_taken", PCF, 32'h40);
    train(32'h10, 0, 32'h0, 0);
    redirect(32'h10);
    step(); check("weak_not", PCF, 32'h14);

    // Jump predicted after one training; alias at same index misses
    train(32'h20, 1, 32'h80, 1);
    redirect(32'h20);
    step(); check("jump_pc", PCF, 32'h80);
    redirect(32'h420);
    step(); check("alias_pc", PCF, 32'h424);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      StallF      = ($urandom_range(0, 5) == 0);
      StallD      = ($urandom_range(0, 5) == 0);
      FlushD      = ($urandom_range(0, 9) == 0);
      RedirectE   = ($urandom_range(0, 7) == 0);
      RedirectPCE = rand_pc();
      UpdateE     = ($urandom_range(0, 2) == 0);
      UpdatePCE   = rand_pc();
      IsJumpE     = ($urandom_range(0, 4) == 0);
      ActualTakenE = IsJumpE | 1'($urandom_range(0, 1));
      ActualTargetE = rand_pc();
      if ($urandom_range(0, 299) == 0) async_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
